mult_div_unit: RTL

- Iterative HI/LO multiply/divide unit in the EX stage, beside the barrel shifter and ALU.
- Consumes the same rs/rt operands from the ID/EX register.
- Produces HI/LO for mfhi/mflo.
- Multi-cycle: control stalls the pipeline while busy is high.

---
 rtl/mult_div_unit_pkg.sv | 19 +
 rtl/md_negate.sv | 15 +
 rtl/mult_div_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit:
// operand width, opType encodings and controller state constants.
package mult_div_unit_pkg;

    localparam int WIDTH = 32;

    // opType comes straight from funct[1:0] of the mult/div instructions
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement: passes the input through, or returns
// ~data + cin. With cin=1 this is a plain negate; chaining cin lets two
// instances negate a double-width value (low half first).
module md_negate #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic         i_cin,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    assign o_data = i_neg ? (~i_data + {{(W-1){1'b0}}, i_cin}) : i_data;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// Operands are converted to magnitudes at load, RUN performs one
// shift-add (multiply) or restoring-subtract (divide) step per cycle on a
// shared double-width accumulator, and FIX restores the result signs and
// writes HI/LO. mthi/mtlo write HI/LO directly while the unit is idle.
module mult_div_unit #(
    parameter int WIDTH = mult_div_unit_pkg::WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       opType,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    import mult_div_unit_pkg::*;

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    md_state_t          r_state;
    md_state_t          w_next;
    logic               w_load;
    logic               w_step;
    logic               w_fin;
    logic [CNT_W-1:0]   r_cnt;

    // Accumulator: multiply keeps {partial product, remaining multiplier};
    // divide keeps {partial remainder, dividend/quotient bits}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_sgn_q;     // product sign, or quotient sign
    logic               r_sgn_r;     // remainder sign (dividend sign)
    logic               r_dz;        // divisor was zero
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Load-time decode and operand magnitudes
    logic               w_is_div;
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_is_div = (opType == MD_DIV) || (opType == MD_DIVU);
    assign w_signed = (opType == MD_MULT) || (opType == MD_DIV);
    assign w_sign_a = w_signed & srcA[WIDTH-1];
    assign w_sign_b = w_signed & srcB[WIDTH-1];

    // 0x80000000 negates to itself and is then read as an unsigned magnitude
    md_negate #(.W(WIDTH)) u_abs_a (
        .i_neg  (w_sign_a),
        .i_cin  (1'b1),
        .i_data (srcA),
        .o_data (w_abs_a)
    );

    md_negate #(.W(WIDTH)) u_abs_b (
        .i_neg  (w_sign_b),
        .i_cin  (1'b1),
        .i_data (srcB),
        .o_data (w_abs_b)
    );

    // One iteration of either algorithm
    logic [WIDTH:0]     w_part;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_step;

    // Restoring divide: shift in the next dividend bit, subtract if it fits.
    // The difference is always below the divisor, so WIDTH bits hold it.
    assign w_part = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge   = (w_part >= {1'b0, r_opnd});
    assign w_sub  = w_part[WIDTH-1:0] - r_opnd;

    // Shift-add multiply: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole word right.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                    (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    assign w_acc_step = r_is_div
        ? {(w_ge ? w_sub : w_part[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge}
        : {w_sum, r_acc[WIDTH-1:1]};

    // Sign restoration in FIX
    logic               w_neg_lo;
    logic               w_neg_hi;
    logic               w_cin_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH-1:0]   w_fix_hi;

    // A zero divisor leaves the all-ones quotient untouched; the remainder
    // (|dividend|) is still re-signed so HI returns the original dividend.
    assign w_neg_lo = r_is_div ? (r_sgn_q & ~r_dz) : r_sgn_q;
    assign w_neg_hi = r_is_div ? r_sgn_r : r_sgn_q;
    // For a 64-bit product negate, the +1 carries into HI only if LO is zero
    assign w_cin_hi = r_is_div ? 1'b1 : (r_acc[WIDTH-1:0] == {WIDTH{1'b0}});

    md_negate #(.W(WIDTH)) u_fix_lo (
        .i_neg  (w_neg_lo),
        .i_cin  (1'b1),
        .i_data (r_acc[WIDTH-1:0]),
        .o_data (w_fix_lo)
    );

    md_negate #(.W(WIDTH)) u_fix_hi (
        .i_neg  (w_neg_hi),
        .i_cin  (w_cin_hi),
        .i_data (r_acc[2*WIDTH-1:WIDTH]),
        .o_data (w_fix_hi)
    );

    // Controller state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and per-state control strobes
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                    w_load = 1'b1;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) w_next = S_FIX;
            end
            S_FIX: begin
                w_fin  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Iteration counter: cleared at load, one count per RUN cycle
    always_ff @(posedge clk) begin
        if (reset)       r_cnt <= '0;
        else if (w_load) r_cnt <= '0;
        else if (w_step) r_cnt <= r_cnt + 1'b1;
    end

    // Datapath: latch magnitudes and sign flags at load, iterate in RUN
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
            r_is_div <= w_is_div;
            r_sgn_q  <= w_sign_a ^ w_sign_b;
            r_sgn_r  <= w_sign_a;
            r_dz     <= (srcB == {WIDTH{1'b0}});
        end else if (w_step) begin
            r_acc    <= w_acc_step;
        end
    end

    // HI/LO: operation result in FIX, else idle moves unless start wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fin) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if ((r_state == S_IDLE) && !start) begin
            if (mthi) r_hi <= wrData;
            if (mtlo) r_lo <= wrData;
        end
    end

    // Completion pulse, coincident with the HI/LO update
    always_ff @(posedge clk) begin
        if (reset) r_done <= 1'b0;
        else       r_done <= w_fin;
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule
